// File: rtl/jtframe_mister_ddrwr_pkg.sv
// Shared constants and state encoding for the DDR3 burst writer.
package jtframe_mister_ddrwr_pkg;

    // ddram_addr[28:25] selecting the upload region, and its byte address
    localparam logic [3:0]  DDR_BASE_IDX  = 4'd3;
    localparam logic [31:0] DDR_BASE_BYTE = 32'h3000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        WRITE
    } state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with one cycle latency.
module jtframe_dual_ram #(
    parameter int dw = 72,
    parameter int aw = 7
)(
    input  logic          clk,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    input  logic [aw-1:0] addr1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem [0:2**aw-1];

    // write port 0, registered read on port 1 (read-before-write)
    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= data0;
        q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtframe_mister_ddrwr.sv
// Byte-stream to DDR3 burst writer: packs bytes little-endian into 64-bit
// words, stages one burst in a buffer and writes it to the upload region.
module jtframe_mister_ddrwr
    import jtframe_mister_ddrwr_pkg::*;
#(
    parameter int         BW   = 7,
    parameter logic [3:0] BASE = DDR_BASE_IDX
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        dump_start,
    input  logic        dump_flush,
    input  logic [7:0]  din,
    input  logic        din_we,
    output logic        din_rdy,
    output logic        busy,
    output logic        done,
    output logic [26:0] byte_cnt,
    input  logic        ddram_busy,
    output logic [7:0]  ddram_burstcnt,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic        ddram_we
);

    localparam int PW = 25 - BW;

    state_t          state, state_nx;
    logic [PW-1:0]   page;
    logic [63:0]     wdata, wdata_nx;
    logic [7:0]      wbe, wbe_nx;
    logic [BW-1:0]   pad_slot, beat, rd_addr, ram_waddr;
    logic [71:0]     ram_wdata, ram_q;
    logic [26:0]     cnt_nx;
    logic            flush_flag, done_set, ram_we;
    logic            accept, last_lane, burst_full, pending, beat_go, beat_last;

    // handshake decode and byte-lane merge of the incoming byte
    always_comb begin
        accept     = (state == FILL) && din_we;
        last_lane  = (byte_cnt[2:0] == 3'd7);
        burst_full = accept && (&byte_cnt[BW+2:0]);
        pending    = |byte_cnt[BW+2:0];
        cnt_nx     = byte_cnt + 27'(accept);
        wdata_nx   = wdata;
        wdata_nx[{byte_cnt[2:0], 3'b000} +: 8] = din;
        wbe_nx     = wbe;
        wbe_nx[byte_cnt[2:0]] = 1'b1;
        beat_go    = ddram_we && !ddram_busy;
        beat_last  = &beat;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        done_set = 1'b0;
        case (state)
            IDLE:  if (dump_start) state_nx = FILL;
            FILL: begin
                if (burst_full) begin
                    state_nx = WRITE;
                end else if (dump_flush) begin
                    if (accept || pending) begin
                        state_nx = PAD;
                    end else begin
                        state_nx = IDLE;
                        done_set = 1'b1;
                    end
                end
            end
            PAD:   if (&pad_slot) state_nx = WRITE;
            WRITE: begin
                // every non-flush burst is full, so a late flush ends the session here
                if (beat_go && beat_last) begin
                    if (flush_flag || dump_flush) begin
                        state_nx = IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_nx = FILL;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // buffer ports: completed words / padding in, prefetch of the next beat out
    always_comb begin
        ram_we    = accept && last_lane;
        ram_waddr = byte_cnt[BW+2:3];
        ram_wdata = {wbe_nx, wdata_nx};
        if (state == PAD) begin
            ram_we    = 1'b1;
            ram_waddr = pad_slot;
            ram_wdata = {wbe, wdata};
        end
        // reading beat+1 as a beat is taken keeps q one step ahead, so
        // data is valid in the same cycle as ddram_we without bubbles
        rd_addr = beat_go ? beat + BW'(1) : beat;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // datapath registers: counters, word assembly, page and flush tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page       <= '0;
            byte_cnt   <= '0;
            wdata      <= '0;
            wbe        <= '0;
            pad_slot   <= '0;
            beat       <= '0;
            flush_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= done_set;
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        page       <= '0;
                        byte_cnt   <= '0;
                        wdata      <= '0;
                        wbe        <= '0;
                        beat       <= '0;
                        flush_flag <= 1'b0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        byte_cnt <= cnt_nx;
                        if (last_lane) begin
                            wdata <= '0;
                            wbe   <= '0;
                        end else begin
                            wdata <= wdata_nx;
                            wbe   <= wbe_nx;
                        end
                    end
                    if (burst_full) begin
                        flush_flag <= dump_flush;
                    end else if (dump_flush) begin
                        pad_slot   <= cnt_nx[BW+2:3];
                        flush_flag <= 1'b1;
                    end
                end
                PAD: begin
                    pad_slot <= pad_slot + BW'(1);
                    wdata    <= '0;
                    wbe      <= '0;
                end
                WRITE: begin
                    if (dump_flush) flush_flag <= 1'b1;
                    if (beat_go) begin
                        beat <= beat + BW'(1);
                        if (beat_last) page <= page + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // output decode; data/BE forced low outside a burst
    always_comb begin
        din_rdy        = (state == FILL);
        busy           = (state != IDLE);
        ddram_we       = (state == WRITE);
        ddram_burstcnt = 8'(1 << BW);
        ddram_addr     = {BASE, page, {BW{1'b0}}};
        ddram_din      = ddram_we ? ram_q[63:0]  : '0;
        ddram_be       = ddram_we ? ram_q[71:64] : '0;
    end

    jtframe_dual_ram #(
        .dw(72),
        .aw(BW)
    ) u_buf (
        .clk   (clk),
        .data0 (ram_wdata),
        .addr0 (ram_waddr),
        .we0   (ram_we),
        .addr1 (rd_addr),
        .q1    (ram_q)
    );

endmodule

// File: tb/tb_jtframe_mister_ddrwr.sv
// Self-checking bench for jtframe_mister_ddrwr: a session-level model of the
// byte stream predicts every beat, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_jtframe_mister_ddrwr;
    import jtframe_mister_ddrwr_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        dump_start = 1'b0, dump_flush = 1'b0;
    logic [7:0]  din = '0;
    logic        din_we = 1'b0;
    logic        din_rdy, busy, done, ddram_we;
    logic [26:0] byte_cnt;
    logic        ddram_busy = 1'b0;
    logic [7:0]  ddram_burstcnt, ddram_be;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;

    jtframe_mister_ddrwr #(.BW(7), .BASE(4'd3)) dut (
        .clk(clk), .rst(rst), .dump_start(dump_start), .dump_flush(dump_flush),
        .din(din), .din_we(din_we), .din_rdy(din_rdy), .busy(busy), .done(done),
        .byte_cnt(byte_cnt), .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt),
        .ddram_addr(ddram_addr), .ddram_din(ddram_din), .ddram_be(ddram_be),
        .ddram_we(ddram_we)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- session model ----------------
    logic [7:0]  mbytes [0:4095];
    int          m_nbytes = 0, m_beat = 0, xfer_cnt = 0, done_cnt = 0;
    bit          m_open = 0, m_flush = 0, m_done = 0;
    logic [63:0] cap_din  [0:511];
    logic [7:0]  cap_be   [0:511];
    logic [28:0] cap_addr [0:511];
    logic        rand_busy = 1'b0;

    function automatic logic [63:0] exp_din(input int e);
        logic [63:0] d = '0;
        for (int j = 0; j < 8; j++) begin
            int o = (e / 128) * 1024 + (e % 128) * 8 + j;
            if (o < m_nbytes) d[8*j +: 8] = mbytes[o];
        end
        return d;
    endfunction

    function automatic logic [7:0] exp_be(input int e);
        logic [7:0] b = '0;
        for (int j = 0; j < 8; j++)
            if ((e / 128) * 1024 + (e % 128) * 8 + j < m_nbytes) b[j] = 1'b1;
        return b;
    endfunction

    // one compare process: outputs vs. model every cycle, then advance model
    always @(negedge clk) begin
        if (rst) begin
            m_open = 0; m_flush = 0; m_done = 0; m_nbytes = 0; m_beat = 0; xfer_cnt = 0;
        end else begin
            bit exp_rdy;
            int due;
            exp_rdy = m_open && !m_flush && !(m_beat < (m_nbytes / 1024) * 128);
            due = m_flush ? ((m_nbytes + 1023) / 1024) * 128 : (m_nbytes / 1024) * 128;
            chk("busy", busy, m_open);
            chk("done", done, m_done);
            chk("din_rdy", din_rdy, exp_rdy);
            chk("byte_cnt", byte_cnt, m_nbytes);
            if (done) done_cnt++;
            if (ddram_we) begin
                if (m_beat >= due) begin
                    chk("ddram_we_extra", ddram_we, 0);
                end else begin
                    chk("ddram_addr", ddram_addr, (DDR_BASE_BYTE >> 3) + (m_beat / 128) * 128);
                    chk("ddram_burstcnt", ddram_burstcnt, 128);
                    chk("ddram_din", ddram_din, exp_din(m_beat));
                    chk("ddram_be", ddram_be, exp_be(m_beat));
                    if (m_beat < 512) begin
                        cap_din[m_beat] = ddram_din;
                        cap_be[m_beat] = ddram_be;
                        cap_addr[m_beat] = ddram_addr;
                    end
                    if (!ddram_busy) begin
                        m_beat++;
                        xfer_cnt++;
                    end
                end
            end
            m_done = 0;
            if (din_we && exp_rdy) begin
                if (m_nbytes < 4096) mbytes[m_nbytes] = din;
                m_nbytes++;
            end
            if (dump_start && !m_open) begin
                m_open = 1; m_flush = 0; m_nbytes = 0; m_beat = 0; xfer_cnt = 0;
            end else if (dump_flush && m_open) begin
                m_flush = 1;
            end
            if (m_open && m_flush && m_beat == ((m_nbytes + 1023) / 1024) * 128) begin
                m_open = 0;
                m_done = 1;
            end
        end
    end

    // arbiter stall generator
    initial forever begin
        @(posedge clk); #1;
        ddram_busy = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        dump_start = 1'b1; tick(); dump_start = 1'b0;
    endtask

    task automatic pulse_flush();
        dump_flush = 1'b1; tick(); dump_flush = 1'b0;
    endtask

    // push n bytes valued (first+i)[7:0], honouring din_rdy
    task automatic send(input int n, input int first, input bit flush_last);
        int sent = 0, budget = 0;
        while (sent < n && budget < 5000) begin
            bit acc;
            din = 8'(first + sent);
            din_we = 1'b1;
            acc = din_rdy;
            dump_flush = flush_last && acc && (sent == n - 1);
            tick();
            dump_flush = 1'b0;
            if (acc) sent++;
            budget++;
        end
        din_we = 1'b0;
        chk("send_complete", sent, n);
    endtask

    task automatic wait_rdy(input int budget);
        int c = 0;
        while (!din_rdy && c < budget) begin tick(); c++; end
        chk("din_rdy_return", din_rdy, 1);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin tick(); c++; end
        chk("done_seen", done, 1);
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset values
        repeat (3) tick();
        chk("rst_din_rdy", din_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_we", ddram_we, 0);
        chk("rst_din", ddram_din, 0);
        chk("rst_be", ddram_be, 0);
        rst = 1'b0;
        tick();

        // 1: one full burst
        pulse_start();
        send(1024, 0, 0);
        wait_rdy(400);
        chk("t1_byte_cnt", byte_cnt, 1024);
        chk("t1_addr", cap_addr[0], 29'h600_0000);
        chk("t1_beat0", cap_din[0], 64'h0706050403020100);
        chk("t1_be127", cap_be[127], 8'hFF);
        chk("t1_xfer", xfer_cnt, 128);
        pulse_flush();
        wait_done(10);

        // 2: partial burst padded on flush; mid-session start ignored
        done_cnt = 0;
        pulse_start();
        send(5, 0, 0);
        pulse_start();
        send(5, 5, 0);
        chk("t2_byte_cnt", byte_cnt, 10);
        pulse_flush();
        wait_done(600);
        repeat (5) tick();
        chk("t2_be0", cap_be[0], 8'hFF);
        chk("t2_din1", cap_din[1][15:0], 16'h0908);
        chk("t2_be1", cap_be[1], 8'h03);
        chk("t2_be2", cap_be[2], 8'h00);
        chk("t2_be127", cap_be[127], 8'h00);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_busy", busy, 0);

        // 3: two bursts, flush on the completing byte: no third burst
        pulse_start();
        send(2048, 0, 1);
        wait_done(600);
        repeat (200) tick();
        chk("t3_addr0", cap_addr[0], 29'h600_0000);
        chk("t3_addr1", cap_addr[128], 29'h600_0080);
        chk("t3_xfer", xfer_cnt, 256);

        // 4: random arbiter stalls
        pulse_start();
        rand_busy = 1'b1;
        send(1024, 0, 0);
        wait_rdy(2000);
        rand_busy = 1'b0;
        chk("t4_xfer", xfer_cnt, 128);
        chk("t4_addr_last", cap_addr[127], 29'h600_0000);
        pulse_flush();
        wait_done(10);

        // 5: din_we held across the FILL->WRITE edge
        pulse_start();
        for (int i = 0; i < 1200; i++) begin
            din = 8'(i); din_we = 1'b1; tick();
        end
        din_we = 1'b0;
        chk("t5_byte_cnt", byte_cnt, 1072);
        pulse_flush();
        wait_done(600);

        // 6: reset at beat 40 of the second burst, then restart at page 0
        pulse_start();
        send(2048, 0, 0);
        begin
            int c = 0;
            while (m_beat < 168 && c < 500) begin tick(); c++; end
            chk("t6_reach_beat", m_beat, 168);
        end
        rst = 1'b1;
        #1;
        chk("t6_we", ddram_we, 0);
        chk("t6_din", ddram_din, 0);
        chk("t6_be", ddram_be, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rdy", din_rdy, 0);
        chk("t6_byte_cnt", byte_cnt, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send(1024, 0, 0);
        wait_rdy(400);
        chk("t6_addr", cap_addr[0], 29'h600_0000);
        pulse_flush();
        wait_done(10);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtframe_mister_ddrwr.md
Name: jtframe_mister_ddrwr

Overview:
Byte-stream to DDR3 burst writer. It is the upload counterpart of the MiSTer DDR ROM download path.
- Core-side logic (NVRAM dump, save-state, debug capture) pushes bytes with a ready/strobe handshake.
- The block packs bytes little-endian into 64-bit words and stages one burst in an on-chip buffer.
- It writes each burst to DDRAM at a fixed base region so the HPS can retrieve the file.
- It sits between the core's dump logic and the MiSTer DDRAM arbiter port.

Parameters:
- BW, 7: log2 of burst length in 64-bit words. Burst = 2^BW words = 2^(BW+3) bytes.
- BASE, 4'd3: ddram_addr[28:25]. Word address 0x600_0000 = byte address 0x3000_0000.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous reset, active high.
- dump_start in 1: pulse; opens a new session, clears page and byte counters.
- dump_flush in 1: pulse; pads and writes the pending partial burst, then ends the session.
- din in 8: byte from core.
- din_we in 1: byte strobe; accepted only when din_rdy=1.
- din_rdy out 1: block can accept a byte this cycle.
- busy out 1: session active (start seen, flush not yet completed).
- done out 1: one-cycle pulse when the flush burst completes.
- byte_cnt out 27: bytes accepted in the current session.
- ddram_busy in 1: arbiter stall; a beat transfers when ddram_we && !ddram_busy.
- ddram_burstcnt out 8: constant 1<<BW.
- ddram_addr out 29: {BASE, page[24-BW:0], BW'b0}; held stable for the whole burst.
- ddram_din out 64: write data beat.
- ddram_be out 8: byte enables of the beat.
- ddram_we out 1: write request/beat valid.

Behaviour:
- Reset values:
  - Outputs: din_rdy=0, busy=0, done=0, byte_cnt=0, ddram_we=0, ddram_din=0, ddram_be=0.
  - State: IDLE, page=0.
  - Reset mid-burst abandons the burst immediately; ddram_we drops asynchronously.
- States:
  - IDLE: din_rdy=0. dump_start -> FILL, clearing page, byte_cnt, word index and byte lane.
  - FILL: din_rdy=1.
    - Each accepted byte goes to lane byte_cnt[2:0], i.e. bits [8*lane+7:8*lane], and sets that lane's BE bit.
    - After lane 7, the 64-bit word plus 8-bit BE is written to buffer slot byte_cnt[BW+2:3].
    - When the last byte of slot 2^BW-1 is written -> WRITE.
    - dump_flush -> PAD. A flush with byte_cnt=0, or exactly on a burst boundary with nothing pending, goes directly to IDLE and pulses done.
  - PAD: din_rdy=0.
    - Completes the partial word with zero data and BE=0.
    - Remaining slots of the burst are written with BE=8'h00.
    - Then -> WRITE with a flush flag set.
  - WRITE: din_rdy=0.
    - ddram_we=1 for 2^BW beats; beat k presents slot k data and BE.
    - Beat index advances only on !ddram_busy.
    - ddram_din/ddram_be must be valid in the same cycle as ddram_we, so the buffer's 1-cycle read latency is hidden by a prefetch register. No bubble between beats unless ddram_busy.
    - After the last beat: page+1, ddram_we=0. With the flush flag set -> IDLE, done=1 for one cycle, busy=0; otherwise -> FILL.
- Handshake and arbitration:
  - din_we with din_rdy=0 is ignored; byte_cnt is unchanged.
  - dump_start while busy is ignored.
  - dump_flush coinciding with the din_we that completes a burst: the byte is taken, the full burst is written, then one extra all-BE=0 burst is not issued. The session ends after the full burst, with done.
  - dump_flush in WRITE is latched and honoured after the burst.
- Widths and wrap:
  - byte_cnt wraps at 2^27.
  - page wraps at 2^(25-BW); the address stays inside the BASE region.
- ddram_burstcnt and ddram_addr never change while ddram_we=1.

Decomposition:
- Shared package constants: the IDX/base-region values (BASE default, DDR base 0x3000_0000) and the state encoding IDLE/FILL/PAD/WRITE.
- Buffer sub-module: jtframe_dual_ram, dw=72 ({be,data}), aw=BW. Port 0 is the write side (FILL/PAD); port 1 is the read side (WRITE prefetch).
- Everything else lives in one module.

Test Plan:
- dump_start, 1024 bytes value=i[7:0], no ddram_busy -> one burst:
  - addr=0x600_0000, burstcnt=128.
  - 128 consecutive beats, beat0 din=0x0706050403020100, all BE=FF.
  - din_rdy=0 during burst; byte_cnt=1024.
- 10 bytes then dump_flush -> one burst:
  - beat0 BE=FF.
  - beat1 din[15:0]=0x0908, BE=03.
  - beats 2..127 BE=00.
  - done pulses once; busy=0.
- 2048 bytes + flush -> two bursts at 0x600_0000 and 0x600_0080, no third burst; done after the second.
- ddram_busy toggled pseudo-randomly during WRITE -> exactly 128 beats transferred, no beat duplicated or skipped, addr stable throughout.
- din_we asserted continuously across the FILL->WRITE edge -> bytes during din_rdy=0 are dropped; byte_cnt counts only accepted bytes.
- rst asserted at beat 40 of a burst -> ddram_we=0 and outputs at reset values the same cycle; a new dump_start restarts at page 0.
